// File: rtl/spi_master_fifo_pkg.sv
// SPI master shared definitions: FSM state encoding, mode bit positions, divider default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: spi_state_e (SPI_IDLE/START/TRANS/STOP), MODE_CPOL/MODE_CPHA indices
// into the 2-bit {CPOL, CPHA} mode field, SPI_DIV_RESET divider value after reset.
package spi_pkg;

   typedef enum logic [1:0] {
      SPI_IDLE  = 2'd0,
      SPI_START = 2'd1,
      SPI_TRANS = 2'd2,
      SPI_STOP  = 2'd3
   } spi_state_e;

   localparam int MODE_CPOL = 1;
   localparam int MODE_CPHA = 0;

   // 62.5 MHz / 2 / 25 = 1.25 MHz SCK
   localparam int SPI_DIV_RESET = 25;

endpackage

// File: rtl/spi_master_fifo_if.sv
// Bundle of the SPI master's CPU-side controls/status and its SPI pins.
// Latency: n/a (wires only).
// Backpressure: n/a; the CPU side observes full/ovf, pushes while full are dropped.
// Signals: push, din{dc,data}, cfg_we, cfg_div, cfg_mode, miso (into the master);
// full, empty, busy, ovf, cs_n, dc, sck, mosi and, with SPI_RX_EN, rx_data/rx_valid (out of it).
// Modports: master = the SPI master block, slave = the CPU/peripheral side.
interface spi_master_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8
);
   logic              push;
   logic [DATA_W:0]   din;
   logic              cfg_we;
   logic [DIV_W-1:0]  cfg_div;
   logic [1:0]        cfg_mode;
   logic              full;
   logic              empty;
   logic              busy;
   logic              ovf;
   logic              cs_n;
   logic              dc;
   logic              sck;
   logic              mosi;
   logic              miso;
`ifdef SPI_RX_EN
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;

   modport master (
      input  push, din, cfg_we, cfg_div, cfg_mode, miso,
      output full, empty, busy, ovf, cs_n, dc, sck, mosi, rx_data, rx_valid
   );
   modport slave (
      output push, din, cfg_we, cfg_div, cfg_mode, miso,
      input  full, empty, busy, ovf, cs_n, dc, sck, mosi, rx_data, rx_valid
   );
`else
   modport master (
      input  push, din, cfg_we, cfg_div, cfg_mode, miso,
      output full, empty, busy, ovf, cs_n, dc, sck, mosi
   );
   modport slave (
      output push, din, cfg_we, cfg_div, cfg_mode, miso,
      input  full, empty, busy, ovf, cs_n, dc, sck, mosi
   );
`endif
endinterface

// File: rtl/spi_master_fifo_txfifo.sv
// Synchronous TX FIFO for {dc, data} words, pointers carry an extra wrap bit.
// Latency: a word written at edge t is visible on dout (empty=0) after edge t.
// Backpressure: push while full is ignored (caller flags overflow); pop while empty ignored.
// Ports: clk, rst (async, active high), push, pop, din[WIDTH], dout[WIDTH], full, empty.
module spi_txfifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   // Equal index with differing wrap bits means the writer lapped the reader.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   // Write is gated by full alone, so a same-cycle pop never rescues a push into a full FIFO.
   assign do_wr = push && !full;
   assign do_rd = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_wr) wr_q <= wr_q + (AW+1)'(1);
         if (do_rd) rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_q[AW-1:0]] <= din;
   end

   assign dout = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/spi_master_fifo.sv
// SPI master with TX FIFO, runtime half-period divider and all four CPOL/CPHA modes.
// Latency: push into empty FIFO while idle at edge t -> pop and cs_n low after edge t+1.
// Backpressure: none toward the CPU; pushes while full are dropped and set sticky ovf.
// Ports: clk, reset (async, active high), bus (spi_master_fifo_if.master):
//   push/din/cfg_we/cfg_div/cfg_mode/miso in; full/empty/busy/ovf/cs_n/dc/sck/mosi out.
// Build option: define SPI_RX_EN to add rx_data/rx_valid and sample miso on sample edges.
module spi_master_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 8,
   parameter int DIV_RESET  = SPI_DIV_RESET
) (
   input  logic           clk,
   input  logic           reset,
   spi_master_fifo_if.master bus
);
   localparam int ECNT_W = $clog2(2*DATA_W + 1);

   spi_state_e        state_q, state_d;
   logic [DIV_W-1:0]  div_q;
   logic [1:0]        mode_q;
   logic              ovf_q, ovf_d;
   logic [DIV_W-1:0]  hcnt_q, hcnt_d;
   logic [DIV_W-1:0]  fdiv_q, fdiv_d;
   logic [1:0]        fmode_q, fmode_d;
   logic [ECNT_W-1:0] ecnt_q, ecnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic              dc_q, dc_d;
   logic              pop;
   logic [DATA_W:0]   fifo_dout;
   logic              fifo_full, fifo_empty;
   logic              tick, lead_edge, sample_edge;
   logic [DIV_W-1:0]  div_eff;

   spi_txfifo #(.WIDTH(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_txfifo (
      .clk   (clk),
      .rst   (reset),
      .push  (bus.push),
      .pop   (pop),
      .din   (bus.din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A programmed divider of 0 runs as 1 so the half-period counter always terminates.
   assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
   assign tick    = (hcnt_q == fdiv_q - DIV_W'(1));
   // ecnt counts down from 2*DATA_W, so an even remaining count marks an odd (leading) edge.
   assign lead_edge   = ~ecnt_q[0];
   assign sample_edge = lead_edge ^ fmode_q[MODE_CPHA];

   // A drop wins over a same-cycle clear so an overflow event is never lost.
   assign ovf_d = (bus.push && fifo_full) ? 1'b1 : (bus.cfg_we ? 1'b0 : ovf_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= DIV_W'(DIV_RESET);
         mode_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (bus.cfg_we) begin
            div_q  <= bus.cfg_div;
            mode_q <= bus.cfg_mode;
         end
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SPI_IDLE;
         hcnt_q  <= '0;
         fdiv_q  <= DIV_W'(1);
         fmode_q <= '0;
         ecnt_q  <= '0;
         sh_q    <= '0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         dc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         fdiv_q  <= fdiv_d;
         fmode_q <= fmode_d;
         ecnt_q  <= ecnt_d;
         sh_q    <= sh_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         dc_q    <= dc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      fdiv_d  = fdiv_q;
      fmode_d = fmode_q;
      ecnt_d  = ecnt_q;
      sh_d    = sh_q;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      dc_d    = dc_q;
      pop     = 1'b0;
      case (state_q)
         SPI_IDLE: begin
            // Idle clock follows the live cfg so a mode change shows on the next cycle.
            sck_d = mode_q[MODE_CPOL];
            if (!fifo_empty) begin
               pop     = 1'b1;
               fdiv_d  = div_eff;
               fmode_d = mode_q;
               dc_d    = fifo_dout[DATA_W];
               cs_n_d  = 1'b0;
               hcnt_d  = '0;
               state_d = SPI_START;
               if (!mode_q[MODE_CPHA]) begin
                  // CPHA=0: first bit must be valid before the first (sampling) edge.
                  mosi_d = fifo_dout[DATA_W-1];
                  sh_d   = {fifo_dout[DATA_W-2:0], 1'b0};
               end else begin
                  sh_d = fifo_dout[DATA_W-1:0];
               end
            end
         end
         SPI_START: begin
            if (tick) begin
               hcnt_d  = '0;
               ecnt_d  = ECNT_W'(2*DATA_W);
               state_d = SPI_TRANS;
            end else begin
               hcnt_d = hcnt_q + DIV_W'(1);
            end
         end
         SPI_TRANS: begin
            if (tick) begin
               hcnt_d = '0;
               sck_d  = ~sck_q;
               ecnt_d = ecnt_q - ECNT_W'(1);
               // Drive edges: leading for CPHA=1, trailing (bar the final one) for CPHA=0.
               if ((lead_edge && fmode_q[MODE_CPHA]) ||
                   (!lead_edge && !fmode_q[MODE_CPHA] && ecnt_q != ECNT_W'(1))) begin
                  mosi_d = sh_q[DATA_W-1];
                  sh_d   = {sh_q[DATA_W-2:0], 1'b0};
               end
               if (ecnt_q == ECNT_W'(1)) state_d = SPI_STOP;
            end else begin
               hcnt_d = hcnt_q + DIV_W'(1);
            end
         end
         SPI_STOP: begin
            if (tick) begin
               hcnt_d  = '0;
               cs_n_d  = 1'b1;
               state_d = SPI_IDLE;
            end else begin
               hcnt_d = hcnt_q + DIV_W'(1);
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   assign bus.full  = fifo_full;
   assign bus.empty = fifo_empty;
   assign bus.busy  = (state_q != SPI_IDLE) || !fifo_empty;
   assign bus.ovf   = ovf_q;
   assign bus.cs_n  = cs_n_q;
   assign bus.dc    = dc_q;
   assign bus.sck   = sck_q;
   assign bus.mosi  = mosi_q;

`ifdef SPI_RX_EN
   logic [DATA_W-1:0] rxsh_q, rx_data_q;
   logic              rx_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxsh_q     <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (state_q == SPI_TRANS && tick && sample_edge)
            rxsh_q <= {rxsh_q[DATA_W-2:0], bus.miso};
         if (state_q == SPI_STOP && tick) begin
            rx_data_q  <= rxsh_q;
            rx_valid_q <= 1'b1;
         end
      end
   end

   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
`else
   logic unused_rx;
   assign unused_rx = bus.miso ^ sample_edge;
`endif
endmodule

// File: tb/tb_spi_master_fifo.sv
// Self-checking bench: a pin-level monitor reconstructs each frame (bits, timing, levels)
// and the main sequence compares it with frames derived from pushed words and cfg.
// Covers reset values, latency, modes, divider, FIFO fill/overflow, mid-frame reset/cfg.
module tb_spi_master_fifo;
   localparam int D = 8;

   typedef struct {
      logic [7:0] data;
      logic       dc;
      logic [1:0] mode;
      int         div;
   } exp_t;

   typedef struct {
      logic [7:0] lead;
      logic [7:0] trail;
      logic       dc;
      logic       cpol;
      logic       sck_end;
      logic       mbad;
      logic       dbad;
      int         edges;
      int         first_hp;
      int         hpmin;
      int         hpmax;
      int         low_len;
      int         t_fall;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   gcyc = 0;
   int   mon_edges = 0;
   int   mon_nfall = 0;
   int   rx_cnt = 0;
   int   obs_base = 0;
   obs_t obs_q[$];
   exp_t exp_q[$];

   spi_master_fifo_if #(.DATA_W(D), .DIV_W(8)) bus ();

   spi_master_fifo #(.DATA_W(D), .FIFO_DEPTH(16), .DIV_W(8), .DIV_RESET(25)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.miso = bus.mosi;

   always #5 clk = ~clk;

   // Pin monitor: samples on the falling clock edge, away from DUT updates.
   initial begin
      obs_t cur;
      logic cs_p, sck_p, mosi_p;
      bit   in_f;
      int   last, hp;
      cs_p = 1'b1; sck_p = 1'b0; mosi_p = 1'b0; in_f = 0; last = 0; hp = 0;
      cur = '{default: 0};
      forever begin
         @(negedge clk);
         gcyc++;
`ifdef SPI_RX_EN
         if (bus.rx_valid === 1'b1) rx_cnt++;
`endif
         if (bus.cs_n === 1'b0 && cs_p === 1'b1) begin
            cur = '{default: 0};
            cur.cpol = bus.sck; cur.dc = bus.dc; cur.t_fall = gcyc; cur.hpmin = 1 << 30;
            last = 0; in_f = 1; mon_edges = 0; mon_nfall++;
         end else if (in_f) begin
            cur.low_len++;
            if (bus.cs_n !== 1'b0) begin
               hp = cur.low_len - last;
               if (hp < cur.hpmin) cur.hpmin = hp;
               if (hp > cur.hpmax) cur.hpmax = hp;
               cur.sck_end = sck_p;
               obs_q.push_back(cur);
               in_f = 0;
            end else begin
               if (bus.sck !== sck_p) begin
                  hp = cur.low_len - last;
                  if (cur.edges == 0) cur.first_hp = hp;
                  else begin
                     if (hp < cur.hpmin) cur.hpmin = hp;
                     if (hp > cur.hpmax) cur.hpmax = hp;
                  end
                  last = cur.low_len;
                  cur.edges++;
                  mon_edges = cur.edges;
                  if (cur.edges % 2 == 1) cur.lead = {cur.lead[6:0], bus.mosi};
                  else cur.trail = {cur.trail[6:0], bus.mosi};
               end else if (bus.mosi !== mosi_p) begin
                  cur.mbad = 1'b1;
               end
               if (bus.dc !== cur.dc) cur.dbad = 1'b1;
            end
         end
         cs_p = bus.cs_n; sck_p = bus.sck; mosi_p = bus.mosi;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [8:0] w, input logic [1:0] m, input int div);
      exp_t e;
      e.data = w[7:0];
      e.dc   = w[8];
      e.mode = m;
      e.div  = (div == 0) ? 1 : div;
      return e;
   endfunction

   task automatic push_w(input logic [8:0] w);
      bus.push = 1'b1;
      bus.din  = w;
      step();
      bus.push = 1'b0;
   endtask

   task automatic set_cfg(input int div, input logic [1:0] m);
      bus.cfg_we   = 1'b1;
      bus.cfg_div  = 8'(div);
      bus.cfg_mode = m;
      step();
      bus.cfg_we = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      bit done;
      done = 0;
      for (int i = 0; i < maxc && !done; i++) begin
         step();
         if (bus.busy === 1'b0 && bus.cs_n === 1'b1) done = 1;
      end
      chk("idle_wait", done, 1);
   endtask

   task automatic wait_edges(input int n, input int maxc);
      bit done;
      done = 0;
      for (int i = 0; i < maxc && !done; i++) begin
         step();
         if (bus.cs_n === 1'b0 && mon_edges == n) done = 1;
      end
      chk("edge_wait", done, 1);
   endtask

   task automatic check_frames();
      obs_t o;
      exp_t e;
      int   n;
      n = obs_q.size() - obs_base;
      chk("frame_count", n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
         o = obs_q[obs_base + i];
         e = exp_q[i];
         chk("edges", o.edges, 2*D);
         chk("data", e.mode[0] ? o.trail : o.lead, e.data);
         chk("dc", o.dc, e.dc);
         chk("cpol", o.cpol, e.mode[1]);
         chk("sck_end", o.sck_end, e.mode[1]);
         chk("first_half", o.first_hp, 2*e.div);
         chk("half_min", o.hpmin, e.div);
         chk("half_max", o.hpmax, e.div);
         chk("cs_low_len", o.low_len, (2*D+2)*e.div);
         chk("mosi_glitch", o.mbad, 0);
         chk("dc_glitch", o.dbad, 0);
      end
      obs_base = obs_q.size();
      exp_q.delete();
   endtask

   initial begin
      logic [8:0] w;
      logic [1:0] m;
      int         b, nf, d, n;
      reset = 1'b1;
      bus.push = 1'b0; bus.din = '0; bus.cfg_we = 1'b0; bus.cfg_div = '0; bus.cfg_mode = '0;
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b0;
      step();

      // Reset state
      chk("rst_cs_n", bus.cs_n, 1);
      chk("rst_sck", bus.sck, 0);
      chk("rst_mosi", bus.mosi, 0);
      chk("rst_dc", bus.dc, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
`ifdef SPI_RX_EN
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_rx_data", bus.rx_data, 0);
`endif

      // 1: default cfg, latency and a full frame of 0xA5
      push_w(9'h0A5);
      exp_q.push_back(mk(9'h0A5, 2'd0, 25));
      chk("lat_cs_n_t1", bus.cs_n, 1);
      chk("lat_empty_t1", bus.empty, 0);
      chk("lat_busy_t1", bus.busy, 1);
      step();
      chk("lat_cs_n_t2", bus.cs_n, 0);
      wait_idle(600);
      chk("busy_after_frame", bus.busy, 0);
      check_frames();

      // 2: mode 3, div 2, dc=1
      set_cfg(2, 2'd3);
      step();
      chk("idle_sck_cpol1", bus.sck, 1);
      push_w(9'h1C3);
      exp_q.push_back(mk(9'h1C3, 2'd3, 2));
      wait_idle(200);
      check_frames();

      // 3: 17 back-to-back pushes fill the FIFO, the 18th is dropped
      m = 2'($urandom_range(0, 3));
      set_cfg(3, m);
      bus.push = 1'b1;
      for (int i = 0; i < 17; i++) begin
         w = 9'($urandom_range(0, 511));
         bus.din = w;
         exp_q.push_back(mk(w, m, 3));
         step();
      end
      bus.push = 1'b0;
      chk("full_after_17", bus.full, 1);
      chk("ovf_before_drop", bus.ovf, 0);
      push_w(9'h1FF);
      chk("ovf_after_drop", bus.ovf, 1);
      chk("full_after_drop", bus.full, 1);
      b = obs_base;
      wait_idle(17*60 + 100);
      chk("ovf_sticky", bus.ovf, 1);
      check_frames();
      for (int i = 1; i < 17 && b + i < obs_q.size(); i++)
         chk("b2b_gap", obs_q[b+i].t_fall - obs_q[b+i-1].t_fall, (2*D+2)*3 + 1);
      set_cfg(3, m);
      chk("ovf_cleared", bus.ovf, 0);

      // 4: reset in the middle of TRANS (after edge 7) aborts and flushes
      set_cfg(4, 2'd1);
      push_w(9'h055);
      push_w(9'h0AA);
      push_w(9'h133);
      wait_edges(7, 200);
      reset = 1'b1;
      #1;
      chk("abort_cs_n", bus.cs_n, 1);
      chk("abort_sck", bus.sck, 0);
      chk("abort_empty", bus.empty, 1);
      chk("abort_busy", bus.busy, 0);
      step();
      reset = 1'b0;
      nf = mon_nfall;
      repeat (200) step();
      chk("no_frames_after_abort", mon_nfall, nf);
      obs_base = obs_q.size();
      exp_q.delete();
      // Reset also restores the default divider and mode 0
      push_w(9'h06C);
      exp_q.push_back(mk(9'h06C, 2'd0, 25));
      wait_idle(600);
      check_frames();

      // 5: div 0 acts as 1; mid-frame mode change applies to the next frame only
      set_cfg(0, 2'd0);
      push_w(9'h0E1);
      push_w(9'h14B);
      exp_q.push_back(mk(9'h0E1, 2'd0, 0));
      exp_q.push_back(mk(9'h14B, 2'd2, 0));
      wait_edges(3, 50);
      set_cfg(0, 2'd2);
      wait_idle(100);
      chk("idle_sck_new_mode", bus.sck, 1);
      check_frames();

      // Randomized bursts under random cfg
      for (int r = 0; r < 6; r++) begin
         d = $urandom_range(0, 4);
         m = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 6);
         set_cfg(d, m);
         for (int k = 0; k < n; k++) begin
            w = 9'($urandom_range(0, 511));
            push_w(w);
            exp_q.push_back(mk(w, m, d));
         end
         wait_idle(n*((2*D+2)*4 + 1) + 50);
         check_frames();
      end

`ifdef SPI_RX_EN
      // 6: loopback receive
      nf = rx_cnt;
      set_cfg(1, 2'($urandom_range(0, 3)));
      push_w(9'h03C);
      wait_idle(100);
      step();
      chk("rx_valid_pulses", rx_cnt - nf, 1);
      chk("rx_data", bus.rx_data, 8'h3C);
      obs_base = obs_q.size();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
